// File: rtl/imsic_msi_sender.sv
// ============================================================================
// Module   : imsic_msi_sender
// Purpose  : Upstream MSI feeder for the per-hart IMSIC CSR gate. Accepts
//            seteipnum_le/be writes on a valid/ready channel, decodes each
//            address into {hart, interrupt file}, buffers legal writes in a
//            FIFO and replays them as timed level pulses on o_msi_info_vld.
//            The receiving gate synchronises and edge-detects those pulses.
// Ports    : clk, rstn (async, active low)
//            i_wr_vld / o_wr_rdy / i_wr_addr / i_wr_data : write channel
//            o_msi_info / o_msi_info_vld                 : {hart,file,id} + strobe
//            o_busy                                      : work pending
//            o_drop_cnt                                  : saturating drop count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imsic_msi_sender #(
    parameter int NR_INTP_FILES   = 7,
    parameter int NR_HARTS        = 4,
    parameter int NR_SRC          = 32,
    parameter int ADDR_W          = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int HOLD_CYCLES     = 4,
    parameter int GAP_CYCLES      = 4,
    parameter int NR_HARTS_WIDTH  = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1,
    parameter int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
    parameter int NR_SRC_WIDTH    = $clog2(NR_SRC),
    parameter int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_wr_vld,
    output logic                      o_wr_rdy,
    input  logic [ADDR_W-1:0]         i_wr_addr,
    input  logic [31:0]               i_wr_data,
    output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
    output logic                      o_msi_info_vld,
    output logic                      o_busy,
    output logic [7:0]                o_drop_cnt
);

    localparam int IDX_W    = $clog2(FIFO_DEPTH);
    localparam int PTR_W    = IDX_W + 1;
    localparam int OCC_W    = PTR_W + 1;
    localparam int CNT_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int HART_LSB = 12 + INTP_FILE_WIDTH;
    localparam int HI_LSB   = HART_LSB + NR_HARTS_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Address / data decode
    // ------------------------------------------------------------------
    logic [11:0]                 w_off;
    logic [INTP_FILE_WIDTH-1:0]  w_file;
    logic [NR_HARTS_WIDTH-1:0]   w_hart;
    logic [ADDR_W-1:0]           w_addr_hi;
    logic                        w_off_le;
    logic                        w_off_be;
    logic [31:0]                 w_id;
    logic                        w_legal;
    logic [MSI_INFO_WIDTH-1:0]   w_info;
    logic                        w_accept;

    assign w_off     = i_wr_addr[11:0];
    assign w_file    = i_wr_addr[12 +: INTP_FILE_WIDTH];
    assign w_hart    = i_wr_addr[HART_LSB +: NR_HARTS_WIDTH];
    assign w_addr_hi = i_wr_addr >> HI_LSB;
    assign w_off_le  = (w_off == 12'h000);
    assign w_off_be  = (w_off == 12'h004);
    assign w_id      = w_off_be ? {i_wr_data[7:0], i_wr_data[15:8], i_wr_data[23:16], i_wr_data[31:24]}
                                : i_wr_data;

    assign w_legal = (w_off_le | w_off_be)
                   && (32'(w_file) < 32'(NR_INTP_FILES))
                   && (32'(w_hart) < 32'(NR_HARTS))
                   && (w_id[31:NR_SRC_WIDTH] == '0)
                   && (w_id != 32'd0)
                   && (w_id < 32'(NR_SRC))
                   && (w_addr_hi == '0);

    assign w_info   = {w_hart, w_file, w_id[NR_SRC_WIDTH-1:0]};
    assign w_accept = i_wr_vld & o_wr_rdy;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                        stg_vld_q;
    logic [MSI_INFO_WIDTH-1:0]   stg_info_q;
    logic [MSI_INFO_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]            wptr_q;
    logic [PTR_W-1:0]            rptr_q;
    logic                        rdy_q;
    logic [7:0]                  drop_q;
    state_t                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        vld_q;
    logic [MSI_INFO_WIDTH-1:0]   info_q;

    logic [PTR_W-1:0]            w_count;
    logic [PTR_W-1:0]            w_count_d;
    logic [OCC_W-1:0]            w_occ_d;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_stg_d;
    logic                        w_rdy_d;

    assign w_count   = wptr_q - rptr_q;
    assign w_push    = stg_vld_q;
    assign w_pop     = (state_q == S_IDLE) && (w_count != '0);
    assign w_stg_d   = w_accept & w_legal;
    assign w_count_d = w_count + PTR_W'(w_push) - PTR_W'(w_pop);

    // The decode stage holds one legal entry on its way into the FIFO, so
    // ready accounts for it too; the stage can therefore never push into a
    // full FIFO.
    assign w_occ_d = {1'b0, w_count_d} + OCC_W'(w_stg_d);
    assign w_rdy_d = (w_occ_d < OCC_W'(FIFO_DEPTH));

    // Decode stage, FIFO pointers, ready and drop counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stg_vld_q  <= 1'b0;
            stg_info_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rdy_q      <= 1'b1;
            drop_q     <= 8'd0;
        end else begin
            stg_vld_q <= w_stg_d;
            if (w_stg_d) begin
                stg_info_q <= w_info;
            end
            if (w_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            rdy_q <= w_rdy_d;
            if (w_accept && !w_legal && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // FIFO storage needs no reset: only slots between the pointers are read
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q[IDX_W-1:0]] <= stg_info_q;
        end
    end

    // Sender FSM: load on pop, hold vld for HOLD_CYCLES, then stay low
    // for GAP_CYCLES before returning to IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            info_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_pop) begin
                        info_q  <= mem_q[rptr_q[IDX_W-1:0]];
                        vld_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        vld_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    vld_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wr_rdy       = rdy_q;
    assign o_msi_info     = info_q;
    assign o_msi_info_vld = vld_q;
    assign o_drop_cnt     = drop_q;
    assign o_busy         = (w_count != '0) | (state_q != S_IDLE) | stg_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_imsic_msi_sender.sv
// ============================================================================
// Module   : tb_imsic_msi_sender
// Purpose  : Scoreboard bench for imsic_msi_sender. A driver issues directed
//            and random MSI writes; a reference model decides legality and
//            the expected {hart,file,id}; a monitor pops expectations on
//            each vld rising edge and checks pulse shape and spacing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imsic_msi_sender;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        i_wr_vld  = 1'b0;
    logic [31:0] i_wr_addr = 32'd0;
    logic [31:0] i_wr_data = 32'd0;
    logic        o_wr_rdy;
    logic [9:0]  o_msi_info;
    logic        o_msi_info_vld;
    logic        o_busy;
    logic [7:0]  o_drop_cnt;

    always #5 clk = ~clk;

    imsic_msi_sender dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_wr_vld       (i_wr_vld),
        .o_wr_rdy       (o_wr_rdy),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .o_msi_info     (o_msi_info),
        .o_msi_info_vld (o_msi_info_vld),
        .o_busy         (o_busy),
        .o_drop_cnt     (o_drop_cnt)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         acc_cyc = 0;
    int         drop_m  = 0;
    bit         stall_seen = 0;
    logic [9:0] expq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // Reference model: legality and payload straight from the address map
    function automatic bit model_legal(input logic [31:0] a, input logic [31:0] d,
                                       output logic [9:0] info);
        int unsigned off, file, hart, hi, id;
        off  = a % 4096;
        file = (a / 4096) % 8;
        hart = (a / 32768) % 4;
        hi   = a / 131072;
        id   = (off == 4) ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
        info = 10'(hart * 256 + file * 32 + (id % 32));
        return (off == 0 || off == 4) && file < 7 && hart < 4 && hi == 0 && id >= 1 && id < 32;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bit         lg;
        logic [9:0] inf;
        int         t;
        @(negedge clk);
        i_wr_vld  = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
        t = 0;
        while (o_wr_rdy !== 1'b1 && t < 200) begin
            stall_seen = 1;
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            timeout_fail("wr_accept");
            i_wr_vld = 1'b0;
            return;
        end
        @(posedge clk);
        lg = model_legal(a, d, inf);
        if (lg) expq.push_back(inf);
        else if (drop_m < 255) drop_m++;
        #1;
        i_wr_vld = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((expq.size() != 0 || o_busy !== 1'b0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) timeout_fail("drain");
    endtask

    // Monitor: one expectation per vld rising edge, plus pulse shape checks
    initial begin
        bit         prev;
        int         hi_len;
        int         last_rise;
        bit         have_cur;
        logic [9:0] cur;
        prev = 0; hi_len = 0; last_rise = -1000; have_cur = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev = 0; hi_len = 0; last_rise = -1000; have_cur = 0;
            end else begin
                if (o_msi_info_vld && !prev) begin
                    total++;
                    if (cyc - last_rise < 9) begin
                        bad++;
                        $display("FAIL spacing actual=%0d required>=9", cyc - last_rise);
                    end
                    last_rise = cyc;
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_msi actual=%0d required=none", o_msi_info);
                        have_cur = 0;
                    end else begin
                        cur = expq.pop_front();
                        have_cur = 1;
                        chk("msi_info", o_msi_info, cur);
                    end
                    hi_len = 1;
                end else if (o_msi_info_vld) begin
                    hi_len++;
                    if (have_cur) chk("info_stable", o_msi_info, cur);
                end else if (prev) begin
                    chk("hold_len", hi_len, 4);
                    if (have_cur) chk("info_after_fall", o_msi_info, cur);
                end
                prev = o_msi_info_vld;
            end
        end
    end

    initial begin
        int t;
        logic [31:0] a, d;
        int unsigned hart, file, off, id, r;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_rdy",  o_wr_rdy, 1);
        chk("rst_vld",  o_msi_info_vld, 0);
        chk("rst_info", o_msi_info, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_drop", o_drop_cnt, 0);

        // Single LE write, latency to vld
        wr(32'h0000_5000, 32'd3);
        t = 0;
        while (o_msi_info_vld !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) timeout_fail("first_vld");
        else chk("latency", cyc - acc_cyc, 2);
        wait_idle();

        // BE write, then three illegal writes
        wr(32'h0000_1004, 32'h0700_0000);
        wr(32'h0000_0008, 32'd5);
        wr(32'h0000_0000, 32'd0);
        wr(32'h0000_0000, 32'd32);
        wait_idle();
        chk("drop_after_illegal", o_drop_cnt, drop_m);

        // Six back-to-back legal writes into a depth-4 FIFO
        stall_seen = 0;
        for (int i = 0; i < 6; i++) wr(32'((i % 4) * 32768 + (i % 7) * 4096), 32'(i + 1));
        chk("rdy_low_when_full", stall_seen, 1);
        wait_idle();

        // Highest legal hart/file/id, then file 7
        wr(32'h0001_E000, 32'd31);
        wr(32'h0000_7000, 32'd1);
        wait_idle();
        chk("drop_file7", o_drop_cnt, drop_m);

        // Random mix of legal and illegal writes
        for (int i = 0; i < 150; i++) begin
            hart = $urandom_range(0, 4);
            file = $urandom_range(0, 7);
            r    = $urandom_range(0, 9);
            off  = (r < 4) ? 0 : (r < 8) ? 4 : (r == 8) ? 8 : $urandom_range(0, 4095);
            id   = $urandom_range(0, 35);
            a    = 32'(hart * 32768 + file * 4096 + off);
            if ($urandom_range(0, 15) == 0) a = a | 32'h0002_0000;
            d    = (off == 4) ? {id[7:0], id[15:8], id[23:16], id[31:24]} : id;
            if ($urandom_range(0, 19) == 0) d = $urandom;
            wr(a, d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        chk("drop_random", o_drop_cnt, drop_m);

        // Saturation of the drop counter
        for (int i = 0; i < 260; i++) wr(32'h0000_0008, 32'd1);
        #1;
        chk("drop_model_sat", o_drop_cnt, drop_m);
        chk("drop_sat", o_drop_cnt, 255);

        // Reset in the middle of a send
        wr(32'h0000_3000, 32'd9);
        t = 0;
        while (o_msi_info_vld !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) timeout_fail("vld_before_reset");
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_vld",  o_msi_info_vld, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_rdy",  o_wr_rdy, 1);
        chk("midrst_drop", o_drop_cnt, 0);
        expq.delete();
        drop_m = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b1;

        // Operation resumes after reset
        wr(32'h0000_2000, 32'd17);
        wait_idle();
        chk("drop_after_reset", o_drop_cnt, drop_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
